// File: rtl/score_bcd_if.sv
// Handshake bundle between a score source (master) and score_bcd_converter (slave).
// Handshake: master raises start with bin valid; the slave accepts only while busy=0,
// ignores start while busy=1, and pulses done for one cycle when bcd/overflow update.
interface score_bcd_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [1:0]            state;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow, state
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow, state
  );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the HEX display encoders.
// Optional BCD_BLANK_EN: leading-zero digits are loaded as 4'hF (segments off).
module score_bcd_converter #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  score_bcd_if.slave  bus
);
  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // When 2^BIN_W <= 10^DIGITS the comparison below is constant false.
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [SW-1:0] SAT9 = {DIGITS{4'd9}};

  function automatic logic [SW-1:0] blank_lead(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (v[4*d +: 4] == 4'd0)) r[4*d +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  logic [1:0]       state_q;
  logic [BIN_W-1:0] shift_q;
  logic [SW-1:0]    scratch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [SW-1:0]    bcd_q;
  logic             overflow_q;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_nxt;
  logic [BIN_W-1:0] shift_nxt;
  logic [SW-1:0]    shown;

  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
    scratch_nxt = {adj[SW-2:0], shift_q[BIN_W-1]};
    shift_nxt   = {shift_q[BIN_W-2:0], 1'b0};
  end

`ifdef BCD_BLANK_EN
  assign shown = blank_lead(scratch_nxt);
`else
  assign shown = scratch_nxt;
`endif

  // The result is loaded on the final shift edge so it is valid during the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            ovf_q     <= (64'(bus.bin) >= LIMIT);
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_nxt;
          shift_q   <= shift_nxt;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= DONE;
            bcd_q      <= ovf_q ? SAT9 : shown;
            overflow_q <= ovf_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;
endmodule
